// File: rtl/ones_count_scheduler.sv
// ones_count_scheduler: two requesters share one serial ones-counting engine.
// A round-robin arbiter grants one word at a time. The word is shifted out
// LSB-first while its 1s are counted, and a done pulse tagged with the
// requester ID ends each job. Every output comes straight from a flop.
module ones_count_scheduler #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [CW-1:0]    count,
    output logic             done,
    output logic             done_id
);

    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             ptr;

    logic             any_req;
    logic             winner;
    logic             last_bit;

    logic             gnt0_d;
    logic             gnt1_d;
    logic             busy_d;
    logic             bit_out_d;
    logic             bit_valid_d;
    logic [CW-1:0]    count_d;
    logic             done_d;
    logic             done_id_d;
    logic [WIDTH-1:0] shreg_d;
    logic [BW-1:0]    bit_cnt_d;
    logic             ptr_d;

    // If both requesters ask, the pointer decides. Otherwise whoever asks wins.
    assign any_req  = req0 | req1;
    assign winner   = (req0 & req1) ? ptr : req1;
    assign last_bit = (bit_cnt == BW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: IDLE -> SHIFT on a request, WIDTH shift cycles, one DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and the datapath.
    // The value of bit_out is looked ahead by one bit so that the flop shows shreg[0].
    always_comb begin
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        busy_d      = 1'b0;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        count_d     = count;
        done_id_d   = done_id;
        shreg_d     = shreg;
        bit_cnt_d   = bit_cnt;
        ptr_d       = ptr;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt0_d      = ~winner;
                    gnt1_d      = winner;
                    busy_d      = 1'b1;
                    bit_valid_d = 1'b1;
                    shreg_d     = winner ? data1 : data0;
                    bit_out_d   = winner ? data1[0] : data0[0];
                    count_d     = '0;
                    done_id_d   = winner;
                    bit_cnt_d   = '0;
                    ptr_d       = ~winner;
                end
            end
            SHIFT: begin
                busy_d    = 1'b1;
                count_d   = count + CW'(shreg[0]);
                shreg_d   = shreg >> 1;
                bit_cnt_d = bit_cnt + BW'(1);
                if (last_bit) begin
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    bit_valid_d = 1'b1;
                    bit_out_d   = shreg[1];
                end
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers. Reset clears everything and drops any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            ptr       <= 1'b0;
        end else begin
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            busy      <= busy_d;
            bit_out   <= bit_out_d;
            bit_valid <= bit_valid_d;
            count     <= count_d;
            done      <= done_d;
            done_id   <= done_id_d;
            shreg     <= shreg_d;
            bit_cnt   <= bit_cnt_d;
            ptr       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_ones_count_scheduler.sv
// Directed self-checking bench for ones_count_scheduler (WIDTH=8, CW=4).
module tb_ones_count_scheduler;

    logic       clk;
    logic       rst;
    logic       req0;
    logic [7:0] data0;
    logic       req1;
    logic [7:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       bit_out;
    logic       bit_valid;
    logic [3:0] count;
    logic       done;
    logic       done_id;

    int total = 0;
    int bad   = 0;

    ones_count_scheduler #(.WIDTH(8), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .count     (count),
        .done      (done),
        .done_id   (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and then sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output in one call.
    task automatic chk_all(input string tag, input logic g0, input logic g1, input logic bz,
                           input logic bo, input logic bv, input logic [3:0] cnt,
                           input logic dn, input logic id);
        chk({tag, ".gnt0"}, gnt0, g0);
        chk({tag, ".gnt1"}, gnt1, g1);
        chk({tag, ".busy"}, busy, bz);
        chk({tag, ".bit_out"}, bit_out, bo);
        chk({tag, ".bit_valid"}, bit_valid, bv);
        chk({tag, ".count"}, count, cnt);
        chk({tag, ".done"}, done, dn);
        chk({tag, ".done_id"}, done_id, id);
    endtask

    // Start in the first SHIFT cycle (the grant cycle). Check WIDTH bit cycles and end in DONE.
    task automatic shift_bits(input string tag, input logic [7:0] word, input logic id);
        int run;
        run = 0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, ".bit_valid"}, bit_valid, 1);
            chk({tag, ".bit_out"}, bit_out, word[i]);
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".run_count"}, count, run);
            chk({tag, ".done"}, done, 0);
            chk({tag, ".done_id"}, done_id, id);
            if (i > 0) begin
                chk({tag, ".gnt0_low"}, gnt0, 0);
                chk({tag, ".gnt1_low"}, gnt1, 0);
            end
            run += int'(word[i]);
            tick();
        end
    endtask

    task automatic check_done(input string tag, input logic [3:0] final_cnt, input logic id);
        chk_all({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, final_cnt, 1'b1, id);
    endtask

    // Leave DONE and check that IDLE holds count and done_id.
    task automatic to_idle(input string tag, input logic [3:0] final_cnt, input logic id);
        tick();
        chk_all({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, final_cnt, 1'b0, id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset with both requests high.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'hFF; data1 = 8'h00;
        tick();
        chk_all("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        chk_all("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Test 3: contention from reset. The pointer starts at 0, so req0 is granted first.
        tick();
        chk_all("c_gnt0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        req0 = 1'b0;
        shift_bits("c_job0", 8'hFF, 1'b0);
        check_done("c_job0", 4'd8, 1'b0);
        to_idle("c_job0", 4'd8, 1'b0);
        tick();
        chk_all("c_gnt1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        req1 = 1'b0;
        shift_bits("c_job1", 8'h00, 1'b1);
        check_done("c_job1", 4'd0, 1'b1);
        to_idle("c_job1", 4'd0, 1'b1);

        // Test 2: single job 8'hB5. Serving req0 leaves the pointer favouring req1.
        req0 = 1'b1; data0 = 8'hB5;
        tick();
        chk_all("s_gnt0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        req0 = 1'b0;
        shift_bits("s_job", 8'hB5, 1'b0);
        check_done("s_job", 4'd5, 1'b0);
        to_idle("s_job", 4'd5, 1'b0);
        tick();
        chk_all("s_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);

        // Test 3b: second simultaneous pair. req1 is served first.
        req0 = 1'b1; data0 = 8'h3C; req1 = 1'b1; data1 = 8'h81;
        tick();
        chk_all("p_gnt1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        req1 = 1'b0;
        shift_bits("p_job1", 8'h81, 1'b1);
        check_done("p_job1", 4'd2, 1'b1);
        to_idle("p_job1", 4'd2, 1'b1);
        tick();
        chk_all("p_gnt0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        req0 = 1'b0;
        shift_bits("p_job0", 8'h3C, 1'b0);
        check_done("p_job0", 4'd4, 1'b0);
        to_idle("p_job0", 4'd4, 1'b0);

        // Test 5: req1 raised during DONE is not granted until after IDLE.
        req0 = 1'b1; data0 = 8'h11;
        tick();
        chk_all("b_gnt0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        req0 = 1'b0;
        shift_bits("b_job0", 8'h11, 1'b0);
        check_done("b_job0", 4'd2, 1'b0);
        req1 = 1'b1; data1 = 8'h0F;
        to_idle("b_job0", 4'd2, 1'b0);
        tick();
        chk_all("b_gnt1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        req1 = 1'b0;
        shift_bits("b_job1", 8'h0F, 1'b1);
        check_done("b_job1", 4'd4, 1'b1);
        to_idle("b_job1", 4'd4, 1'b1);

        // Test 6: changing data0 after the grant does not affect the job.
        req0 = 1'b1; data0 = 8'h01;
        tick();
        chk_all("d_gnt0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        req0 = 1'b0; data0 = 8'hFF;
        shift_bits("d_job", 8'h01, 1'b0);
        check_done("d_job", 4'd1, 1'b0);
        to_idle("d_job", 4'd1, 1'b0);

        // Test 4: reset in the 4th SHIFT cycle aborts the job without a done pulse.
        req0 = 1'b1; data0 = 8'hFF;
        tick();
        chk_all("r_gnt0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        req0 = 1'b0;
        tick();
        tick();
        tick();
        chk("r_mid.count", count, 3);
        chk("r_mid.bit_valid", bit_valid, 1);
        rst = 1'b1;
        tick();
        chk_all("r_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("r_nodone", done, 0);
            chk("r_idle_busy", busy, 0);
        end
        req0 = 1'b1; data0 = 8'hFF;
        tick();
        chk_all("r_gnt0b", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        req0 = 1'b0;
        shift_bits("r_job", 8'hFF, 1'b0);
        check_done("r_job", 4'd8, 1'b0);
        to_idle("r_job", 4'd8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ones_count_scheduler.md
Name: ones_count_scheduler

Overview:
Shares one serial ones-counting engine between two requesters. Each requester presents a WIDTH-bit word with a request. The scheduler grants requesters round-robin and serialises the granted word LSB-first onto a bit stream. It accumulates the number of 1s, then reports the result with a done pulse tagged by requester ID.

Parameters:
WIDTH, 8, bits per submitted word (>=2)
CW, 4, count width; must satisfy 2^CW > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req0  input  1  requester 0 request; held high until gnt0
data0  input  WIDTH  requester 0 word; sampled on grant edge
req1  input  1  requester 1 request; held high until gnt1
data1  input  WIDTH  requester 1 word; sampled on grant edge
gnt0  output  1  one-cycle pulse: requester 0 word accepted
gnt1  output  1  one-cycle pulse: requester 1 word accepted
busy  output  1  high in SHIFT and DONE
bit_out  output  1  current serial bit, LSB first
bit_valid  output  1  bit_out is valid (SHIFT only)
count  output  CW  running and final count of 1s
done  output  1  one-cycle pulse: count holds final result
done_id  output  1  requester served by current/last job

Behaviour:
- All outputs are registered. States: IDLE, SHIFT, DONE.
- Reset (rst=1 at an edge, any state, including mid-SHIFT):
  - state=IDLE.
  - All outputs = 0.
  - Shift register = 0, bit counter = 0.
  - Priority pointer = 0 (requester 0 favoured).
  - The aborted job produces no done.
- IDLE: req0/req1 are sampled at each edge. If either is high:
  - Winner is the only requester asserting, or, if both assert, the requester named by the pointer.
  - At that edge: shift register <= winner's data; count <= 0; done_id <= winner; state <= SHIFT.
  - gnt<winner> = 1 for exactly the next cycle.
- Priority pointer: at the grant edge, the pointer <= NOT winner. The just-served requester then has lowest priority.
- SHIFT lasts exactly WIDTH cycles:
  - In each cycle: bit_valid=1 and bit_out=shreg[0].
  - At the edge ending each SHIFT cycle: count <= count + shreg[0]; shreg >>= 1; bit counter++.
  - After the WIDTH-th bit: state <= DONE.
- DONE lasts one cycle:
  - done=1, bit_valid=0, count=popcount of the granted word, done_id=served requester.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle T gives:
  - gnt in cycle T+1.
  - Bits in cycles T+1 through T+WIDTH.
  - done in cycle T+WIDTH+1.
  - Earliest next grant is in cycle T+WIDTH+3 (IDLE in T+WIDTH+2).
- Requests during SHIFT/DONE are not sampled. They must be held and are serviced from IDLE.
- A req still high in IDLE after its gnt is treated as a new request. Requesters drop req the cycle after gnt.
- Arithmetic: count never exceeds WIDTH, so no overflow or wrap for a legal CW.
- Hold rules:
  - count and done_id hold their values from DONE through IDLE until the next grant edge.
  - bit_out = 0 whenever bit_valid = 0.
- data0/data1 changes outside the grant edge have no effect on the job in flight.

Test Plan:
1. Reset: rst=1 for 2 cycles with req0=req1=1 -> all outputs 0, no gnt. Release rst -> gnt0 in the cycle after the first IDLE edge (pointer=0).
2. Single job: req0=1, data0=8'hB5 -> gnt0 pulse 1 cycle. bit_out sequence is 1,0,1,0,1,1,0,1 over 8 bit_valid cycles. done=1 in the following cycle with count=5, done_id=0. busy is low again the cycle after.
3. Contention: req0=1 (8'hFF) and req1=1 (8'h00) together from reset -> req0 first (count=8, done_id=0). Then req1 is granted from the next IDLE (count=0, done_id=1). A second simultaneous pair -> req1 is served first (pointer toggled).
4. Reset mid-operation: rst=1 in the 4th SHIFT cycle of data0=8'hFF -> next cycle count=0, bit_valid=0, no done pulse. The new job after release runs a full 8 bits with count=8.
5. Request during busy: raise req1 (8'h0F) during DONE of a req0 job -> no gnt1 in DONE. gnt1 follows the next IDLE cycle; the result is count=4, done_id=1.
6. Data stability: change data0 from 8'h01 to 8'hFF during SHIFT -> result count=1 (the sampled word is used).
